// File: rtl/rock_scheduler.sv
// rock_scheduler: steps the F/A motion setpoints by at most one unit per
// settle window. Arbitration between F and A is round-robin, and steps are
// clamped to the configured bounds.
module rock_scheduler #(
  parameter int F_INIT = 5,
  parameter int A_INIT = 5,
  parameter int F_MIN  = 1,
  parameter int F_MAX  = 15,
  parameter int A_MIN  = 0,
  parameter int A_MAX  = 15,
  parameter int SETTLE = 8
) (
  input  logic       FclkDff,
  input  logic       reset,
  input  logic       enable,
  input  logic       Fhoog,
  input  logic       Flaag,
  input  logic       Ahoog,
  input  logic       Alaag,
  output logic [3:0] F,
  output logic [3:0] A,
  output logic       step_f,
  output logic       step_a,
  output logic       sat,
  output logic       conflict,
  output logic       busy,
  output logic       F0,
  output logic       AF0
);

  localparam logic [3:0] LP_F_INIT = 4'(F_INIT);
  localparam logic [3:0] LP_A_INIT = 4'(A_INIT);
  localparam logic [3:0] LP_F_MIN  = 4'(F_MIN);
  localparam logic [3:0] LP_F_MAX  = 4'(F_MAX);
  localparam logic [3:0] LP_A_MIN  = 4'(A_MIN);
  localparam logic [3:0] LP_A_MAX  = 4'(A_MAX);
  localparam logic [7:0] LP_CNT_LD = 8'(SETTLE - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SETTLE = 1'b1} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt;
  logic       r_rr_a;     // 1: A wins when both channels request
  logic [3:0] r_f, r_a;
  logic       r_step_f, r_step_a, r_sat, r_conflict;

  logic w_idle, w_req_f, w_req_a, w_grant, w_sel_a;
  logic w_f_up, w_f_dn, w_a_up, w_a_dn, w_sat, w_conf_now;

  // Both directions high cancels the request for that channel.
  assign w_idle     = (r_state == S_IDLE);
  assign w_req_f    = enable & (Fhoog ^ Flaag);
  assign w_req_a    = enable & (Ahoog ^ Alaag);
  assign w_grant    = w_idle & (w_req_f | w_req_a);
  assign w_sel_a    = w_req_a & (~w_req_f | r_rr_a);
  assign w_conf_now = (Fhoog & Flaag) | (Ahoog & Alaag);

  // Bound check happens before the step, so the 4-bit values never wrap.
  assign w_f_up = w_grant & ~w_sel_a & Fhoog & (r_f < LP_F_MAX);
  assign w_f_dn = w_grant & ~w_sel_a & Flaag & (r_f > LP_F_MIN);
  assign w_a_up = w_grant &  w_sel_a & Ahoog & (r_a < LP_A_MAX);
  assign w_a_dn = w_grant &  w_sel_a & Alaag & (r_a > LP_A_MIN);
  assign w_sat  = w_grant & ~(w_f_up | w_f_dn | w_a_up | w_a_dn);

  // State register
  always_ff @(posedge FclkDff or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: a grant opens a window; the window closes when the count runs out
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_grant)        w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_cnt == 8'd0)  w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  // Setpoints, round-robin pointer, settle counter and registered pulses
  always_ff @(posedge FclkDff or posedge reset) begin
    if (reset) begin
      r_f        <= LP_F_INIT;
      r_a        <= LP_A_INIT;
      r_rr_a     <= 1'b0;
      r_cnt      <= 8'd0;
      r_step_f   <= 1'b0;
      r_step_a   <= 1'b0;
      r_sat      <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_step_f <= w_f_up | w_f_dn;
      r_step_a <= w_a_up | w_a_dn;
      r_sat    <= w_sat;
      if (w_idle) r_conflict <= w_conf_now;
      if (w_f_up) r_f <= r_f + 4'd1;
      if (w_f_dn) r_f <= r_f - 4'd1;
      if (w_a_up) r_a <= r_a + 4'd1;
      if (w_a_dn) r_a <= r_a - 4'd1;
      if (w_grant) begin
        r_rr_a <= ~w_sel_a;
        r_cnt  <= LP_CNT_LD;
      end else if (!w_idle && r_cnt != 8'd0) begin
        r_cnt  <= r_cnt - 8'd1;
      end
    end
  end

  // Outputs: status decodes straight from state and setpoints
  always_comb begin
    F        = r_f;
    A        = r_a;
    step_f   = r_step_f;
    step_a   = r_step_a;
    sat      = r_sat;
    conflict = r_conflict;
    busy     = (r_state == S_SETTLE);
    F0       = (r_f == LP_F_MIN);
    AF0      = (r_f == LP_F_MIN) & (r_a == LP_A_MIN);
  end

endmodule

// File: tb/tb_rock_scheduler.sv
// Bench for rock_scheduler: a timestamp-based reference model checked every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_rock_scheduler;
  localparam int SETTLE = 8;
  localparam int F_INIT = 5, A_INIT = 5;
  localparam int F_MIN = 1, F_MAX = 15, A_MIN = 0, A_MAX = 15;

  logic FclkDff = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0, Fhoog = 1'b0, Flaag = 1'b0, Ahoog = 1'b0, Alaag = 1'b0;
  logic [3:0] F, A;
  logic step_f, step_a, sat, conflict, busy, F0, AF0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 FclkDff = ~FclkDff;

  rock_scheduler #(
    .F_INIT(F_INIT), .A_INIT(A_INIT), .F_MIN(F_MIN), .F_MAX(F_MAX),
    .A_MIN(A_MIN), .A_MAX(A_MAX), .SETTLE(SETTLE)
  ) dut (
    .FclkDff(FclkDff), .reset(reset), .enable(enable),
    .Fhoog(Fhoog), .Flaag(Flaag), .Ahoog(Ahoog), .Alaag(Alaag),
    .F(F), .A(A), .step_f(step_f), .step_a(step_a), .sat(sat),
    .conflict(conflict), .busy(busy), .F0(F0), .AF0(AF0)
  );

  // Reference model: a grant at edge g makes the block busy for edges
  // g..g+SETTLE-1 and ready to grant again at edge g+SETTLE+1.
  int  mF = F_INIT, mA = A_INIT, cyc = 0, last = -1000;
  bit  mPreferA = 0, mSf = 0, mSa = 0, mSat = 0, mConf = 0;

  initial begin
    bit rf, ra, pickA;
    logic [14:0] exp_v, act_v;
    forever begin
      @(posedge FclkDff);
      if (reset) begin
        mF = F_INIT; mA = A_INIT; mPreferA = 0; cyc = 0; last = -1000;
        mSf = 0; mSa = 0; mSat = 0; mConf = 0;
      end else begin
        cyc++;
        mSf = 0; mSa = 0; mSat = 0;
        if (cyc - last > SETTLE) begin
          mConf = (Fhoog && Flaag) || (Ahoog && Alaag);
          rf = enable && (Fhoog != Flaag);
          ra = enable && (Ahoog != Alaag);
          if (rf || ra) begin
            pickA = ra && (!rf || mPreferA);
            if (!pickA) begin
              if (Fhoog && mF < F_MAX)      begin mF = mF + 1; mSf = 1; end
              else if (Flaag && mF > F_MIN) begin mF = mF - 1; mSf = 1; end
              else mSat = 1;
            end else begin
              if (Ahoog && mA < A_MAX)      begin mA = mA + 1; mSa = 1; end
              else if (Alaag && mA > A_MIN) begin mA = mA - 1; mSa = 1; end
              else mSat = 1;
            end
            mPreferA = !pickA;
            last = cyc;
          end
        end
      end
      #1;
      exp_v = {4'(mF), 4'(mA), mSf, mSa, mSat, mConf,
               ((cyc - last) < SETTLE), (mF == F_MIN), (mF == F_MIN && mA == A_MIN)};
      act_v = {F, A, step_f, step_a, sat, conflict, busy, F0, AF0};
      n_cmp++;
      if (exp_v !== act_v) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t {F,A,sf,sa,sat,conf,busy,F0,AF0} got %h want %h",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge FclkDff);
  endtask

  task automatic idle_inputs();
    Fhoog = 0; Flaag = 0; Ahoog = 0; Alaag = 0;
  endtask

  task automatic do_reset();
    reset = 1; tick(1); reset = 0;
  endtask

  initial begin
    // reset values
    tick(2);
    chk("rst_F", F, 5); chk("rst_A", A, 5); chk("rst_busy", busy, 0);
    chk("rst_step_f", step_f, 0); chk("rst_conflict", conflict, 0);
    reset = 0; enable = 1;

    // hold Fhoog: steps at edges 1, 10, 19, 28
    Fhoog = 1;
    tick(1);  chk("up_F1", F, 6); chk("up_stepf1", step_f, 1); chk("up_busy1", busy, 1);
    tick(1);  chk("up_stepf_clr", step_f, 0); chk("up_busy2", busy, 1);
    tick(8);  chk("up_F10", F, 7); chk("up_stepf10", step_f, 1);
    tick(18); chk("up_F28", F, 9);
    idle_inputs(); tick(10);

    // hold Flaag: four steps to F_MIN then a saturated grant
    do_reset(); Flaag = 1;
    tick(37); chk("dn_F", F, 1); chk("dn_F0", F0, 1); chk("dn_sat", sat, 1);
    chk("dn_stepf", step_f, 0);
    idle_inputs(); tick(10);

    // Fhoog + Alaag: grants alternate F, A, F, A
    do_reset(); Fhoog = 1; Alaag = 1;
    tick(1); chk("alt_F1", F, 6); chk("alt_A1", A, 5);
    tick(9); chk("alt_A10", A, 4); chk("alt_F10", F, 6);
    tick(9); chk("alt_F19", F, 7);
    tick(9); chk("alt_A28", A, 3);
    idle_inputs(); tick(10);

    // both F directions: no grant, conflict flagged
    do_reset(); Fhoog = 1; Flaag = 1;
    tick(5); chk("cf_conflict", conflict, 1); chk("cf_busy", busy, 0); chk("cf_F", F, 5);
    Flaag = 0;
    tick(1); chk("cf_F_after", F, 6); chk("cf_conflict_clr", conflict, 0);
    idle_inputs(); tick(10);

    // enable dropped mid-window: window completes, nothing further granted
    do_reset(); Ahoog = 1;
    tick(1); chk("en_A1", A, 6);
    tick(2); enable = 0;
    tick(6); chk("en_busy_end", busy, 0); chk("en_A_hold", A, 6);
    tick(5); chk("en_A_still", A, 6);
    enable = 1;
    tick(1); chk("en_A_regrant", A, 7);
    idle_inputs(); tick(10);

    // asynchronous reset in the 4th settle cycle after F=7
    do_reset(); Fhoog = 1;
    tick(10); chk("ar_F7", F, 7);
    tick(3); reset = 1; #1;
    chk("ar_F", F, 5); chk("ar_A", A, 5); chk("ar_busy", busy, 0);
    Fhoog = 0; tick(1); reset = 0;
    Flaag = 1; Alaag = 1;
    tick(120); chk("af0_F", F, 1); chk("af0_A", A, 0); chk("af0_AF0", AF0, 1);
    idle_inputs(); tick(10);

    // random phase
    for (int i = 0; i < 4000; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) Fhoog = ~Fhoog;
      if ($urandom_range(0, 7) == 0) Flaag = ~Flaag;
      if ($urandom_range(0, 7) == 0) Ahoog = ~Ahoog;
      if ($urandom_range(0, 7) == 0) Alaag = ~Alaag;
      reset = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    reset = 0; idle_inputs(); tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
